// File: rtl/uart_ram_pkg.sv
// uart_ram_pkg: shared constants for the dual-queue RAM controller.
package uart_ram_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    localparam logic HALF_AB = 1'b1;
    localparam logic HALF_BA = 1'b0;
endpackage

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2: two-requester round-robin arbiter; priority passes to the loser after each grant.
module uart_rr_arb2
    import uart_ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic prio;

    assign grant[0] = req[0] && (!req[1] || prio == SEL_A);
    assign grant[1] = req[1] && (!req[0] || prio == SEL_B);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prio <= SEL_A;
        else if (grant[0]) prio <= SEL_B;
        else if (grant[1]) prio <= SEL_A;
endmodule

// File: rtl/uart_ram_queue_ctrl.sv
// uart_ram_queue_ctrl: two ring-buffer queues (A->B high half, B->A low half) sharing one dual-port RAM.
// Optional flush ports enabled by UART_RAM_FLUSH_EN.
module uart_ram_queue_ctrl
    import uart_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
`ifdef UART_RAM_FLUSH_EN
    input  logic              i_a_flush,
    input  logic              i_b_flush,
`endif
    output logic [ADDR_W:0]   o_ram_r_addr,
    input  logic [DATA_W-1:0] i_ram_r_data,
    output logic [ADDR_W:0]   o_ram_w_addr,
    output logic [DATA_W-1:0] o_ram_w_data,
    output logic              o_ram_we,
    input  logic              i_a_push,
    input  logic [DATA_W-1:0] i_a_push_data,
    output logic              o_a_push_ready,
    input  logic              i_b_push,
    input  logic [DATA_W-1:0] i_b_push_data,
    output logic              o_b_push_ready,
    input  logic              i_a_pop,
    output logic              o_a_pop_grant,
    output logic              o_a_pop_valid,
    output logic [DATA_W-1:0] o_a_pop_data,
    input  logic              i_b_pop,
    output logic              o_b_pop_grant,
    output logic              o_b_pop_valid,
    output logic [DATA_W-1:0] o_b_pop_data,
    output logic [ADDR_W:0]   o_a_rx_count,
    output logic [ADDR_W:0]   o_b_rx_count,
    output logic              o_a_tx_full,
    output logic              o_b_tx_full
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_ab, rd_ptr_ab, wr_ptr_ba, rd_ptr_ba;
    logic [ADDR_W-1:0] wr_ab_nxt, wr_ba_nxt;
    logic [ADDR_W:0]   cnt_ab, cnt_ba;
    logic              full_ab, full_ba, empty_ab, empty_ba;
    logic              flush_ab, flush_ba;
    logic [1:0]        wreq, wgnt, rreq, rgnt;

`ifdef UART_RAM_FLUSH_EN
    assign flush_ab = i_b_flush;
    assign flush_ba = i_a_flush;
`else
    assign flush_ab = 1'b0;
    assign flush_ba = 1'b0;
`endif

    assign full_ab  = cnt_ab == DEPTH;
    assign full_ba  = cnt_ba == DEPTH;
    assign empty_ab = cnt_ab == '0;
    assign empty_ba = cnt_ba == '0;

    // Writes are gated by reset so the RAM never sees a strobe while reset is held.
    assign wreq = {i_b_push && !full_ba, i_a_push && !full_ab} & {2{i_rst_n}};
    assign rreq = {i_b_pop && !empty_ab && !flush_ab, i_a_pop && !empty_ba && !flush_ba};

    uart_rr_arb2 u_warb (.clk(i_clk), .rst_n(i_rst_n), .req(wreq), .grant(wgnt));
    uart_rr_arb2 u_rarb (.clk(i_clk), .rst_n(i_rst_n), .req(rreq), .grant(rgnt));

    assign o_a_push_ready = wgnt[0];
    assign o_b_push_ready = wgnt[1];
    assign o_a_pop_grant  = rgnt[0];
    assign o_b_pop_grant  = rgnt[1];
    assign o_ram_we       = |wgnt;
    assign o_ram_w_addr   = wgnt[0] ? {HALF_AB, wr_ptr_ab} : {HALF_BA, wr_ptr_ba};
    assign o_ram_w_data   = wgnt[0] ? i_a_push_data : i_b_push_data;
    assign o_ram_r_addr   = rgnt[0] ? {HALF_BA, rd_ptr_ba} : {HALF_AB, rd_ptr_ab};
    assign o_a_pop_data   = i_ram_r_data;
    assign o_b_pop_data   = i_ram_r_data;
    assign o_a_rx_count   = cnt_ba;
    assign o_b_rx_count   = cnt_ab;
    assign o_a_tx_full    = full_ab;
    assign o_b_tx_full    = full_ba;

    assign wr_ab_nxt = wr_ptr_ab + ADDR_W'(wgnt[0]);
    assign wr_ba_nxt = wr_ptr_ba + ADDR_W'(wgnt[1]);

    // A flush snaps rd_ptr onto the post-edge wr_ptr, discarding any same-cycle push too.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wr_ptr_ab     <= '0;
            rd_ptr_ab     <= '0;
            wr_ptr_ba     <= '0;
            rd_ptr_ba     <= '0;
            cnt_ab        <= '0;
            cnt_ba        <= '0;
            o_a_pop_valid <= 1'b0;
            o_b_pop_valid <= 1'b0;
        end else begin
            wr_ptr_ab     <= wr_ab_nxt;
            wr_ptr_ba     <= wr_ba_nxt;
            rd_ptr_ab     <= flush_ab ? wr_ab_nxt : rd_ptr_ab + ADDR_W'(rgnt[1]);
            rd_ptr_ba     <= flush_ba ? wr_ba_nxt : rd_ptr_ba + ADDR_W'(rgnt[0]);
            cnt_ab        <= flush_ab ? '0 : cnt_ab + (ADDR_W+1)'(wgnt[0]) - (ADDR_W+1)'(rgnt[1]);
            cnt_ba        <= flush_ba ? '0 : cnt_ba + (ADDR_W+1)'(wgnt[1]) - (ADDR_W+1)'(rgnt[0]);
            o_a_pop_valid <= rgnt[0];
            o_b_pop_valid <= rgnt[1];
        end
endmodule

// File: tb/tb_uart_ram_queue_ctrl.sv
// tb_uart_ram_queue_ctrl: directed vectors plus corner sequences for the dual-queue controller.
module tb_uart_ram_queue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [8:0] ram_r_addr, ram_w_addr;
    logic [7:0] ram_r_data, ram_w_data;
    logic       ram_we;
    logic       a_push, b_push, a_pop, b_pop;
    logic [7:0] a_push_data, b_push_data;
    logic       a_ready, b_ready, a_grant, b_grant, a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [8:0] a_rx, b_rx;
    logic       a_full, b_full;
`ifdef UART_RAM_FLUSH_EN
    logic       a_flush, b_flush;
`endif
    logic [7:0] mem [512];
    int n_vec, n_cmp, n_fail;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_w_addr] <= ram_w_data;
        ram_r_data <= mem[ram_r_addr];
    end

    uart_ram_queue_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
`ifdef UART_RAM_FLUSH_EN
        .i_a_flush(a_flush), .i_b_flush(b_flush),
`endif
        .o_ram_r_addr(ram_r_addr), .i_ram_r_data(ram_r_data),
        .o_ram_w_addr(ram_w_addr), .o_ram_w_data(ram_w_data), .o_ram_we(ram_we),
        .i_a_push(a_push), .i_a_push_data(a_push_data), .o_a_push_ready(a_ready),
        .i_b_push(b_push), .i_b_push_data(b_push_data), .o_b_push_ready(b_ready),
        .i_a_pop(a_pop), .o_a_pop_grant(a_grant), .o_a_pop_valid(a_valid), .o_a_pop_data(a_data),
        .i_b_pop(b_pop), .o_b_pop_grant(b_grant), .o_b_pop_valid(b_valid), .o_b_pop_data(b_data),
        .o_a_rx_count(a_rx), .o_b_rx_count(b_rx), .o_a_tx_full(a_full), .o_b_tx_full(b_full)
    );

    typedef struct {
        logic a_push; logic [7:0] a_data; logic b_push; logic [7:0] b_data;
        logic a_pop; logic b_pop;
        logic a_rdy; logic b_rdy; logic a_gnt; logic b_gnt;
        logic [8:0] w_addr; logic [8:0] r_addr;
        logic a_val; logic b_val; logic [7:0] p_data;
        logic [8:0] a_rx; logic [8:0] b_rx;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        a_push = 1'b0; b_push = 1'b0; a_pop = 1'b0; b_pop = 1'b0;
        a_push_data = 8'h00; b_push_data = 8'h00;
`ifdef UART_RAM_FLUSH_EN
        a_flush = 1'b0; b_flush = 1'b0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1,8'hA0,1'b1,8'hB0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 9'h100,9'h000, 1'b0,1'b0,8'h00, 9'd0,9'd1};
        vecs[1]  = '{1'b1,8'hA1,1'b1,8'hB1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 9'h000,9'h000, 1'b0,1'b0,8'h00, 9'd1,9'd1};
        vecs[2]  = '{1'b1,8'hA2,1'b1,8'hB2,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 9'h101,9'h000, 1'b0,1'b0,8'h00, 9'd1,9'd2};
        vecs[3]  = '{1'b1,8'hA3,1'b1,8'hB3,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 9'h001,9'h000, 1'b0,1'b0,8'h00, 9'd2,9'd2};
        vecs[4]  = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b1, 1'b0,1'b0,1'b1,1'b0, 9'h000,9'h000, 1'b1,1'b0,8'hB1, 9'd1,9'd2};
        vecs[5]  = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1, 9'h000,9'h100, 1'b0,1'b1,8'hA0, 9'd1,9'd1};
        vecs[6]  = '{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, 9'h000,9'h101, 1'b0,1'b1,8'hA2, 9'd1,9'd0};
        vecs[7]  = '{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 9'h000,9'h000, 1'b0,1'b0,8'h00, 9'd1,9'd0};
        vecs[8]  = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0, 9'h000,9'h001, 1'b1,1'b0,8'hB3, 9'd0,9'd0};
        vecs[9]  = '{1'b0,8'h00,1'b0,8'h00,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 9'h000,9'h000, 1'b0,1'b0,8'h00, 9'd0,9'd0};
        vecs[10] = '{1'b1,8'h11,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 9'h102,9'h000, 1'b0,1'b0,8'h00, 9'd0,9'd1};
        vecs[11] = '{1'b1,8'h22,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 9'h103,9'h000, 1'b0,1'b0,8'h00, 9'd0,9'd2};
        vecs[12] = '{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, 9'h000,9'h102, 1'b0,1'b1,8'h11, 9'd0,9'd1};
        vecs[13] = '{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b1, 9'h000,9'h103, 1'b0,1'b1,8'h22, 9'd0,9'd0};

        idle();
        #1 rst_n = 1'b0;
        a_push = 1'b1; b_push = 1'b1; a_pop = 1'b1; b_pop = 1'b1;
        #2;
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_grant", 32'(b_grant), 32'd0);
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_rx", 32'(a_rx), 32'd0);
        chk("rst_b_rx", 32'(b_rx), 32'd0);
        chk("rst_a_full", 32'(a_full), 32'd0);
        n_vec++;
        do_reset();

        for (int i = 0; i < 14; i++) begin
            a_push = vecs[i].a_push; a_push_data = vecs[i].a_data;
            b_push = vecs[i].b_push; b_push_data = vecs[i].b_data;
            a_pop = vecs[i].a_pop; b_pop = vecs[i].b_pop;
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].a_rdy));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].b_rdy));
            chk($sformatf("v%0d_a_grant", i), 32'(a_grant), 32'(vecs[i].a_gnt));
            chk($sformatf("v%0d_b_grant", i), 32'(b_grant), 32'(vecs[i].b_gnt));
            chk($sformatf("v%0d_we", i), 32'(ram_we), 32'(vecs[i].a_rdy | vecs[i].b_rdy));
            if (vecs[i].a_rdy || vecs[i].b_rdy) begin
                chk($sformatf("v%0d_w_addr", i), 32'(ram_w_addr), 32'(vecs[i].w_addr));
                chk($sformatf("v%0d_w_data", i), 32'(ram_w_data),
                    32'(vecs[i].a_rdy ? vecs[i].a_data : vecs[i].b_data));
            end
            if (vecs[i].a_gnt || vecs[i].b_gnt)
                chk($sformatf("v%0d_r_addr", i), 32'(ram_r_addr), 32'(vecs[i].r_addr));
            tick();
            chk($sformatf("v%0d_a_valid", i), 32'(a_valid), 32'(vecs[i].a_val));
            chk($sformatf("v%0d_b_valid", i), 32'(b_valid), 32'(vecs[i].b_val));
            if (vecs[i].a_val) chk($sformatf("v%0d_a_data", i), 32'(a_data), 32'(vecs[i].p_data));
            if (vecs[i].b_val) chk($sformatf("v%0d_b_data", i), 32'(b_data), 32'(vecs[i].p_data));
            chk($sformatf("v%0d_a_rx", i), 32'(a_rx), 32'(vecs[i].a_rx));
            chk($sformatf("v%0d_b_rx", i), 32'(b_rx), 32'(vecs[i].b_rx));
            chk($sformatf("v%0d_fulls", i), 32'({a_full, b_full}), 32'd0);
            n_vec++;
        end
        idle();

        // Fill Q_AB, refuse the 257th push, then pop one and see the push land on the wrapped pointer.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            a_push = 1'b1; a_push_data = 8'(i);
            #1;
            chk("fill_ready", 32'(a_ready), 32'd1);
            chk("fill_addr", 32'(ram_w_addr), 32'(9'h100 + 9'(i)));
            tick();
        end
        chk("fill_full", 32'(a_full), 32'd1);
        chk("fill_b_rx", 32'(b_rx), 32'd256);
        chk("fill_b_full", 32'(b_full), 32'd0);
        a_push_data = 8'hEE;
        #1;
        chk("full_ready", 32'(a_ready), 32'd0);
        chk("full_we", 32'(ram_we), 32'd0);
        tick();
        chk("full_b_rx", 32'(b_rx), 32'd256);
        b_pop = 1'b1;
        #1;
        chk("full_pop_ready", 32'(a_ready), 32'd0);
        chk("full_pop_grant", 32'(b_grant), 32'd1);
        chk("full_pop_raddr", 32'(ram_r_addr), 32'h100);
        tick();
        chk("full_pop_valid", 32'(b_valid), 32'd1);
        chk("full_pop_data", 32'(b_data), 32'h00);
        chk("full_pop_rx", 32'(b_rx), 32'd255);
        chk("full_pop_full", 32'(a_full), 32'd0);
        b_pop = 1'b0;
        #1;
        chk("wrap_ready", 32'(a_ready), 32'd1);
        chk("wrap_addr", 32'(ram_w_addr), 32'h100);
        chk("wrap_data", 32'(ram_w_data), 32'hEE);
        tick();
        chk("wrap_full", 32'(a_full), 32'd1);
        idle();
        n_vec++;

        // Simultaneous push and pop on Q_BA holding 5 entries.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b_push = 1'b1; b_push_data = 8'h50 + 8'(i);
            tick();
        end
        chk("same_pre_rx", 32'(a_rx), 32'd5);
        for (int i = 0; i < 2; i++) begin
            b_push = 1'b1; b_push_data = 8'h55 + 8'(i); a_pop = 1'b1;
            #1;
            chk("same_b_ready", 32'(b_ready), 32'd1);
            chk("same_w_addr", 32'(ram_w_addr), 32'(5 + i));
            chk("same_a_grant", 32'(a_grant), 32'd1);
            chk("same_r_addr", 32'(ram_r_addr), 32'(i));
            tick();
            chk("same_rx", 32'(a_rx), 32'd5);
            chk("same_data", 32'(a_data), 32'(8'h50 + 8'(i)));
        end
        n_vec++;

        // Asynchronous reset while a pop is in flight and both devices are pushing.
        b_push = 1'b0; a_pop = 1'b1;
        tick();
        chk("arst_pre_valid", 32'(a_valid), 32'd1);
        a_pop = 1'b0; a_push = 1'b1; b_push = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a_valid), 32'd0);
        chk("arst_a_rx", 32'(a_rx), 32'd0);
        chk("arst_b_rx", 32'(b_rx), 32'd0);
        chk("arst_we", 32'(ram_we), 32'd0);
        chk("arst_ready", 32'({a_ready, b_ready}), 32'd0);
        tick();
        chk("arst_hold_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("arst_first_a", 32'(a_ready), 32'd1);
        chk("arst_first_b", 32'(b_ready), 32'd0);
        tick();
        chk("arst_second_b", 32'(b_ready), 32'd1);
        tick();
        idle();
        n_vec++;

`ifdef UART_RAM_FLUSH_EN
        // Flush Q_AB with a push and a pop arriving in the same cycle.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a_push = 1'b1; a_push_data = 8'h31 + 8'(i);
            tick();
        end
        chk("flush_pre_rx", 32'(b_rx), 32'd3);
        a_push_data = 8'h34; b_flush = 1'b1; b_pop = 1'b1;
        #1;
        chk("flush_b_grant", 32'(b_grant), 32'd0);
        chk("flush_a_ready", 32'(a_ready), 32'd1);
        tick();
        chk("flush_rx", 32'(b_rx), 32'd0);
        chk("flush_valid", 32'(b_valid), 32'd0);
        a_push = 1'b0; b_flush = 1'b0;
        #1;
        chk("flush_post_grant", 32'(b_grant), 32'd0);
        tick();
        chk("flush_post_rx", 32'(b_rx), 32'd0);
        idle();
        n_vec++;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_ram_queue_ctrl.md
Name: uart_ram_queue_ctrl

Overview:
Controller that turns one shared 2*2^ADDR_W x DATA_W simple dual-port RAM into two independent ring-buffer queues.
- Q_AB: device A pushes, device B pops. Lives in the high RAM half.
- Q_BA: device B pushes, device A pops. Lives in the low RAM half.
- Owns all head/tail pointers and occupancy counts, and round-robin arbitrates the single RAM write port and single RAM read port between the two devices.
- Sits between the UART-side engine (A) and CPU bus bridge (B) and the block RAM.

Parameters:
ADDR_W, 8, log2 entries per queue; RAM address width is ADDR_W+1
DATA_W, 8, byte width of each entry

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
o_ram_r_addr  out  ADDR_W+1  RAM read address; RAM returns data one clock later
i_ram_r_data  in  DATA_W  RAM read data
o_ram_w_addr  out  ADDR_W+1  RAM write address
o_ram_w_data  out  DATA_W  RAM write data
o_ram_we  out  1  RAM write enable
i_a_push / i_b_push  in  1  push request
i_a_push_data / i_b_push_data  in  DATA_W  push data
o_a_push_ready / o_b_push_ready  out  1  push accepted this cycle (combinational)
i_a_pop / i_b_pop  in  1  pop request
o_a_pop_grant / o_b_pop_grant  out  1  pop accepted this cycle (combinational)
o_a_pop_valid / o_b_pop_valid  out  1  registered; pop data valid this cycle
o_a_pop_data / o_b_pop_data  out  DATA_W  equals i_ram_r_data
o_a_rx_count / o_b_rx_count  out  ADDR_W+1  entries waiting for the device (Q_BA / Q_AB)
o_a_tx_full / o_b_tx_full  out  1  the device's push queue is full

Behaviour:
- State per queue:
  - wr_ptr and rd_ptr: ADDR_W bits each, wrap modulo 2^ADDR_W.
  - count: ADDR_W+1 bits, range 0..2^ADDR_W.
  - full = (count == 2^ADDR_W); empty = (count == 0).
- Address mapping:
  - Q_AB address = {1'b1, ptr}.
  - Q_BA address = {1'b0, ptr}.
- Write arbitration:
  - Requests: wreq_a = i_a_push && !full_AB; wreq_b = i_b_push && !full_BA.
  - If only one device requests, it wins.
  - If both request, the winner is given by w_prio.
  - On every write grant, w_prio moves to the non-granted device.
  - The winner's push_ready = 1; RAM write is driven the same cycle; its queue wr_ptr increments at the clock edge.
  - When no write is granted: o_ram_we = 0; address and data are don't-care but held at the B-side values.
- Read arbitration:
  - Requests: rreq_a = i_a_pop && !empty_BA; rreq_b = i_b_pop && !empty_AB.
  - Same round-robin scheme, using a separate r_prio.
  - The grant drives o_ram_r_addr and increments rd_ptr at the edge.
  - The granted device's pop_valid is 1 on the next cycle, with pop_data = i_ram_r_data on that cycle.
  - Pop latency is 1 clock.
- Count update:
  - +1 on push grant, -1 on pop grant of the same queue.
  - A push and a pop on the same queue in the same cycle leave count unchanged.
- Full/empty boundaries:
  - A push to a full queue is never granted; ready stays 0 and the request is held.
  - A pop on an empty queue is never granted.
- Read-after-write: an entry written at edge N is poppable in cycle N+1. The RAM has no bypass requirement because the pop address is issued after the write edge.
- Wrap-around: pointers roll from 2^ADDR_W-1 to 0. Count distinguishes full from empty.
- Reset, asynchronous, including mid-transfer:
  - Pointers, counts, pop_valid = 0.
  - w_prio = r_prio = A.
  - o_ram_we = 0 while i_rst_n is low.
  - RAM contents are not cleared; both queues read as empty.

Optional Feature:
UART_RAM_FLUSH_EN
- With the macro: adds inputs i_a_flush and i_b_flush (1 bit each).
  - i_x_flush empties the queue device x pops from: rd_ptr <= next wr_ptr, count <= 0.
  - A push granted into that queue in the same cycle is also discarded.
  - The flushing device's pop grant is suppressed that cycle.
  - A pop_valid already in flight still completes.
- Without the macro: no flush ports, no flush logic.

Decomposition:
- Package uart_ram_pkg holds:
  - SEL_A / SEL_B constants.
  - HALF_AB = 1'b1, HALF_BA = 1'b0.
  - Default ADDR_W / DATA_W.
- Sub-module uart_rr_arb2: 2-requester round-robin arbiter (req[1:0] -> grant[1:0], prio flop with async reset), instantiated twice, once for read and once for write.

Test Plan:
- Reset, then A pushes 0x11, 0x22, then B pops twice -> RAM writes to 0x100 and 0x101; B pop_valid with 0x11 then 0x22; rx_count goes 2, 1, 0.
- A and B push every cycle for 4 cycles from reset -> grants alternate A, B, A, B; o_a_tx_full = o_b_tx_full = 0; each count = 2.
- A pushes 256 entries with no pops -> o_a_tx_full = 1 and the 257th push gets ready = 0. B pops one -> the next A push is accepted at address 0x100 (wrap).
- Same-cycle push and pop on Q_BA with count 5 -> count stays 5; both pointers advance.
- Assert i_rst_n low mid-pop -> pop_valid = 0 and counts = 0 immediately (async); after release, the first contended grant goes to A.
- UART_RAM_FLUSH_EN: Q_AB holds 3 entries and i_b_flush is asserted with a simultaneous A push -> o_b_rx_count = 0 next cycle; B pop is not granted.
